// File: rtl/rv_core_pkg.sv
// Shared core package: register-file geometry, data width and write-back source tags.
package rv_core_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_ALU,
        WB_LSU,
        WB_MDU
    } wb_src_e;

endpackage

// File: rtl/rf_writeback_arb_if.sv
// Write-back bus: ALU/LSU/MDU result sources, issue tags, and the registered RF write port.
// Handshake: a source transfers in a cycle where valid && ready; valid/rd/wd stay stable until then.
interface rf_writeback_arb_if #(
    parameter int XLEN = rv_core_pkg::XLEN
);
    import rv_core_pkg::*;

    logic                  alu_valid;
    logic [REG_ADDR_W-1:0] alu_rd;
    logic [XLEN-1:0]       alu_wd;
    logic                  alu_stall;

    logic                  lsu_valid;
    logic                  lsu_ready;
    logic [REG_ADDR_W-1:0] lsu_rd;
    logic [XLEN-1:0]       lsu_wd;

    logic                  mdu_valid;
    logic                  mdu_ready;
    logic [REG_ADDR_W-1:0] mdu_rd;
    logic [XLEN-1:0]       mdu_wd;

    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_rd;
    logic [XLEN-1:0]       rf_wd;

    logic                  iss_valid;
    logic [REG_ADDR_W-1:0] iss_rd;
    logic [NUM_REGS-1:0]   busy;

    // Pipeline / result-producer side.
    modport master (
        output alu_valid, alu_rd, alu_wd,
        output lsu_valid, lsu_rd, lsu_wd,
        output mdu_valid, mdu_rd, mdu_wd,
        output iss_valid, iss_rd,
        input  alu_stall, lsu_ready, mdu_ready,
        input  rf_we, rf_rd, rf_wd, busy
    );

    // Arbiter side.
    modport slave (
        input  alu_valid, alu_rd, alu_wd,
        input  lsu_valid, lsu_rd, lsu_wd,
        input  mdu_valid, mdu_rd, mdu_wd,
        input  iss_valid, iss_rd,
        output alu_stall, lsu_ready, mdu_ready,
        output rf_we, rf_rd, rf_wd, busy
    );

endinterface

// File: rtl/rf_writeback_arb_scoreboard.sv
// Pending-write bitmap: set on issue, cleared on the matching register-file write.
// Only built when WB_SCOREBOARD_EN is defined.
`ifdef WB_SCOREBOARD_EN
module wb_scoreboard
    import rv_core_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_idx,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_idx,
    output logic [NUM_REGS-1:0]   busy
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Clear is applied first so a same-cycle re-issue of the same register stays pending.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_idx] = 1'b0;
        end
        if (set_en && (set_idx != '0)) begin
            busy_d[set_idx] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule
`endif

// File: rtl/rf_writeback_arb.sv
// Register-file write-back arbiter: ALU > LSU > MDU priority with MDU anti-starvation.
// Optional pending-write scoreboard enabled by WB_SCOREBOARD_EN.
module rf_writeback_arb #(
    parameter int XLEN       = rv_core_pkg::XLEN,
    parameter int STARVE_LIM = 4
) (
    input  logic            clk,
    input  logic            rst,
    rf_writeback_arb_if.slave bus
);
    import rv_core_pkg::*;

    localparam int                CNT_W   = $clog2(STARVE_LIM + 1);
    localparam logic [CNT_W-1:0]  LIM     = CNT_W'(STARVE_LIM);
    localparam logic [CNT_W-1:0]  LIM_M1  = CNT_W'(STARVE_LIM - 1);

    wb_src_e               grant;
    logic                  xfer;
    logic [REG_ADDR_W-1:0] sel_rd;
    logic [XLEN-1:0]       sel_wd;

    logic                  rf_we_q,     rf_we_d;
    logic [REG_ADDR_W-1:0] rf_rd_q,     rf_rd_d;
    logic [XLEN-1:0]       rf_wd_q,     rf_wd_d;
    logic [CNT_W-1:0]      starve_cnt_q, starve_cnt_d;
    logic                  alu_stall_q, alu_stall_d;

    // Grant: a saturated starvation counter lets a waiting MDU pre-empt everything.
    always_comb begin
        grant = WB_NONE;
        if (rst) begin
            if ((starve_cnt_q == LIM) && bus.mdu_valid) begin
                grant = WB_MDU;
            end else if (bus.alu_valid) begin
                grant = WB_ALU;
            end else if (bus.lsu_valid) begin
                grant = WB_LSU;
            end else if (bus.mdu_valid) begin
                grant = WB_MDU;
            end
        end
    end

    assign bus.lsu_ready = (grant == WB_LSU);
    assign bus.mdu_ready = (grant == WB_MDU);

    always_comb begin
        xfer   = 1'b0;
        sel_rd = '0;
        sel_wd = '0;
        unique case (grant)
            WB_ALU: begin
                xfer   = 1'b1;
                sel_rd = bus.alu_rd;
                sel_wd = bus.alu_wd;
            end
            WB_LSU: begin
                xfer   = 1'b1;
                sel_rd = bus.lsu_rd;
                sel_wd = bus.lsu_wd;
            end
            WB_MDU: begin
                xfer   = 1'b1;
                sel_rd = bus.mdu_rd;
                sel_wd = bus.mdu_wd;
            end
            default: begin
                xfer   = 1'b0;
            end
        endcase
    end

    // Writes to x0 are accepted but dropped; rd/wd only move on a real write.
    always_comb begin
        rf_we_d = xfer && (sel_rd != '0);
        rf_rd_d = rf_we_d ? sel_rd : rf_rd_q;
        rf_wd_d = rf_we_d ? sel_wd : rf_wd_q;
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        alu_stall_d  = 1'b0;
        if (!bus.mdu_valid || (grant == WB_MDU)) begin
            starve_cnt_d = '0;
        end else begin
            if (starve_cnt_q != LIM) begin
                starve_cnt_d = starve_cnt_q + CNT_W'(1);
            end
            // Hold the ALU off in the cycle the forced MDU grant will happen.
            alu_stall_d = (starve_cnt_q == LIM_M1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rf_we_q      <= 1'b0;
            rf_rd_q      <= '0;
            rf_wd_q      <= '0;
            starve_cnt_q <= '0;
            alu_stall_q  <= 1'b0;
        end else begin
            rf_we_q      <= rf_we_d;
            rf_rd_q      <= rf_rd_d;
            rf_wd_q      <= rf_wd_d;
            starve_cnt_q <= starve_cnt_d;
            alu_stall_q  <= alu_stall_d;
        end
    end

    assign bus.rf_we     = rf_we_q;
    assign bus.rf_rd     = rf_rd_q;
    assign bus.rf_wd     = rf_wd_q;
    assign bus.alu_stall = alu_stall_q;

`ifdef WB_SCOREBOARD_EN
    logic [NUM_REGS-1:0] busy_w;

    // Clearing on the transfer makes busy drop in the same cycle rf_we is seen high.
    wb_scoreboard u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .set_en  (bus.iss_valid),
        .set_idx (bus.iss_rd),
        .clr_en  (rf_we_d),
        .clr_idx (rf_rd_d),
        .busy    (busy_w)
    );

    assign bus.busy = busy_w;
`else
    logic unused_iss;
    assign unused_iss = ^{bus.iss_valid, bus.iss_rd};
    assign bus.busy   = '0;
`endif

endmodule

// File: tb/tb_rf_writeback_arb.sv
// Bench for rf_writeback_arb: directed scenarios plus random traffic against a reference model.
module tb_rf_writeback_arb;
  import rv_core_pkg::*;

  localparam int XL  = 32;
  localparam int LIM = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rf_writeback_arb_if #(.XLEN(XL)) bus ();

  rf_writeback_arb #(.XLEN(XL), .STARVE_LIM(LIM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h @%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  logic [37:0] exp_q[$];          // {we, rd, wd} expected on the RF port next cycle
  int          mdu_wait;
  logic        exp_stall;
  logic [31:0] busy_m;
  logic [4:0]  last_rd;
  logic [31:0] last_wd;

  always @(negedge clk) begin
    logic [37:0] e;
    int          g;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        we;
    if (!rst) begin
      exp_q.delete();
      exp_q.push_back('0);
      mdu_wait  = 0;
      exp_stall = 1'b0;
      busy_m    = '0;
      last_rd   = '0;
      last_wd   = '0;
    end else begin
      if (exp_q.size() == 0) begin
        chk("exp_q_underflow", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        chk("rf_port", {26'd0, bus.rf_we, bus.rf_rd, bus.rf_wd}, {26'd0, e});
      end
      chk("alu_stall", 64'(bus.alu_stall), 64'(exp_stall));
      chk("busy", 64'(bus.busy), 64'(busy_m));

      // 0 none, 1 alu, 2 lsu, 3 mdu
      if (bus.mdu_valid && mdu_wait >= LIM) g = 3;
      else if (bus.alu_valid)               g = 1;
      else if (bus.lsu_valid)               g = 2;
      else if (bus.mdu_valid)               g = 3;
      else                                  g = 0;
      chk("lsu_ready", 64'(bus.lsu_ready), 64'(g == 2));
      chk("mdu_ready", 64'(bus.mdu_ready), 64'(g == 3));

      rd = '0; wd = '0;
      if (g == 1) begin rd = bus.alu_rd; wd = bus.alu_wd; end
      if (g == 2) begin rd = bus.lsu_rd; wd = bus.lsu_wd; end
      if (g == 3) begin rd = bus.mdu_rd; wd = bus.mdu_wd; end
      we = (g != 0) && (rd != 0);
      if (we) begin last_rd = rd; last_wd = wd; end
      exp_q.push_back({we, last_rd, last_wd});

      exp_stall = bus.mdu_valid && (g != 3) && (mdu_wait == LIM - 1);
      if (bus.mdu_valid && (g != 3)) mdu_wait = (mdu_wait + 1 > LIM) ? LIM : mdu_wait + 1;
      else                           mdu_wait = 0;
`ifdef WB_SCOREBOARD_EN
      if (we) busy_m[rd] = 1'b0;
      if (bus.iss_valid && bus.iss_rd != 0) busy_m[bus.iss_rd] = 1'b1;
`endif
    end
  end

  // ---------------- driver ----------------
  logic lsu_acc, mdu_acc;

  task automatic step();
    @(negedge clk);
    lsu_acc = bus.lsu_valid && bus.lsu_ready;
    mdu_acc = bus.mdu_valid && bus.mdu_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_wd = '0;
    bus.lsu_valid = 1'b0; bus.lsu_rd = '0; bus.lsu_wd = '0;
    bus.mdu_valid = 1'b0; bus.mdu_rd = '0; bus.mdu_wd = '0;
    bus.iss_valid = 1'b0; bus.iss_rd = '0;
  endtask

  task automatic rand_cycle(input int alu_pct);
    step();
    if (bus.alu_stall) bus.alu_valid = 1'b0;
    else bus.alu_valid = ($urandom_range(0, 99) < alu_pct);
    bus.alu_rd = 5'($urandom_range(0, 31));
    bus.alu_wd = $urandom;
    if (!bus.lsu_valid || lsu_acc) begin
      bus.lsu_valid = ($urandom_range(0, 99) < 30);
      bus.lsu_rd    = 5'($urandom_range(0, 31));
      bus.lsu_wd    = $urandom;
    end
    if (!bus.mdu_valid || mdu_acc) begin
      bus.mdu_valid = ($urandom_range(0, 99) < 30);
      bus.mdu_rd    = 5'($urandom_range(0, 31));
      bus.mdu_wd    = $urandom;
    end
    bus.iss_valid = ($urandom_range(0, 99) < 20);
    bus.iss_rd    = 5'($urandom_range(0, 31));
  endtask

  task automatic starve_run(input string nm);
    int mdu_at = -1;
    int stalls = 0;
    bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd12; bus.mdu_wd = $urandom;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'($urandom_range(1, 31)); bus.alu_wd = $urandom;
    for (int c = 0; c < 8; c++) begin
      step();
      if (mdu_acc && mdu_at < 0) begin
        mdu_at = c;
        bus.mdu_valid = 1'b0;
      end
      if (bus.alu_stall) stalls++;
      bus.alu_valid = !bus.alu_stall;
      bus.alu_rd    = 5'($urandom_range(1, 31));
      bus.alu_wd    = $urandom;
    end
    bus.alu_valid = 1'b0;
    chk({nm, "_mdu_accept_cycle"}, 64'(mdu_at), 64'd4);
    chk({nm, "_stall_count"}, 64'(stalls), 64'd1);
  endtask

  initial begin
    int lsu_at;
    int mdu_at;

    // Reset with every source valid: nothing may be acknowledged or written.
    idle_inputs();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_wd = 32'h1111_1111;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd2; bus.lsu_wd = 32'h2222_2222;
    bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd3; bus.mdu_wd = 32'h3333_3333;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd4;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_rf_we", 64'(bus.rf_we), 64'd0);
    chk("reset_rf_rd", 64'(bus.rf_rd), 64'd0);
    chk("reset_rf_wd", 64'(bus.rf_wd), 64'd0);
    chk("reset_alu_stall", 64'(bus.alu_stall), 64'd0);
    chk("reset_lsu_ready", 64'(bus.lsu_ready), 64'd0);
    chk("reset_mdu_ready", 64'(bus.mdu_ready), 64'd0);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle_inputs();
    step();

    // Single ALU write: visible one cycle later for exactly one cycle.
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_wd = 32'hDEAD_BEEF;
    step();
    bus.alu_valid = 1'b0;
    step();
    chk("alu_wr_we", 64'(bus.rf_we), 64'd0);
    chk("alu_wr_rd_hold", 64'(bus.rf_rd), 64'd5);
    chk("alu_wr_wd_hold", 64'(bus.rf_wd), 64'hDEAD_BEEF);

    // All three valid: ALU, then LSU, then MDU on consecutive cycles.
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_wd = 32'hA1A1_0001;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd3; bus.lsu_wd = 32'hB2B2_0003;
    bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd7; bus.mdu_wd = 32'hC3C3_0007;
    lsu_at = -1; mdu_at = -1;
    for (int c = 0; c < 6; c++) begin
      step();
      bus.alu_valid = 1'b0;
      if (lsu_acc) begin lsu_at = c; bus.lsu_valid = 1'b0; end
      if (mdu_acc) begin mdu_at = c; bus.mdu_valid = 1'b0; end
    end
    chk("order_lsu_cycle", 64'(lsu_at), 64'd1);
    chk("order_mdu_cycle", 64'(mdu_at), 64'd2);

    // MDU starved by a continuously valid ALU; run twice to show the counter restarts.
    starve_run("starve1");
    step();
    starve_run("starve2");

    // Load to x0: accepted, never written.
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd0; bus.lsu_wd = 32'h0000_1234;
    step();
    chk("x0_lsu_accept", 64'(lsu_acc), 64'd1);
    bus.lsu_valid = 1'b0;
    step();
    chk("x0_rf_we", 64'(bus.rf_we), 64'd0);

`ifdef WB_SCOREBOARD_EN
    // Issue rd=9, then write rd=9 while rd=9 is re-issued: stays busy.
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
    step();
    bus.iss_valid = 1'b0;
    chk("sb_set_9", 64'(bus.busy[9]), 64'd1);
    bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd9; bus.mdu_wd = 32'h0909_0909;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
    step();
    chk("sb_mdu_accept", 64'(mdu_acc), 64'd1);
    bus.mdu_valid = 1'b0; bus.iss_valid = 1'b0;
    chk("sb_set_wins", 64'(bus.busy[9]), 64'd1);
    step();
    chk("sb_still_busy", 64'(bus.busy[9]), 64'd1);
`endif

    // Random traffic, light then heavy ALU load, with a reset in the middle.
    for (int i = 0; i < 400; i++) rand_cycle(40);
    rst = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    for (int i = 0; i < 600; i++) rand_cycle(85);
    idle_inputs();
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
